// File: rtl/tx_scheduler_pkg.sv
// Shared definitions for the transmit scheduler: network packet geometry,
// default parameter values and the scheduler state encoding.
package tx_scheduler_pkg;

  localparam int unsigned NETWORK_SLICES = 4;
  localparam int unsigned NETWORK_WIDTH  = 8;
  localparam int unsigned PACKET_BITS    = NETWORK_SLICES * NETWORK_WIDTH;

  localparam int unsigned DEFAULT_FRAME_BITS     = 64;
  localparam int unsigned DEFAULT_BIT_PERIOD     = 8;
  localparam int unsigned DEFAULT_GUARD_BITS     = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_SORT,
    SEND,
    GUARD
  } tx_state_t;

endpackage

// File: rtl/tx_scheduler_bit_timer.sv
// Bit-period phase counter: strobe on phase 0, last_phase on the final clock
// of each period while enabled; clear forces the phase back to 0.
module bit_timer #(
  parameter int unsigned PERIOD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic strobe,
  output logic last_phase
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] phase;
  logic          at_last;

  assign at_last = (phase == PW'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase <= '0;
    end else if (enable) begin
      phase <= at_last ? '0 : phase + 1'b1;
    end
  end

  assign strobe     = enable && (phase == '0);
  assign last_phase = enable && at_last;

endmodule

// File: rtl/tx_scheduler.sv
// Transmit scheduler: hands a packet to the sorter, serialises the sorted
// frame LSB first, then idles for a guard period. Optional sorter watchdog
// is built when TX_SCHEDULER_TIMEOUT_EN is defined.
module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_BITS     = DEFAULT_FRAME_BITS,
  parameter int unsigned BIT_PERIOD     = DEFAULT_BIT_PERIOD,
  parameter int unsigned GUARD_BITS     = DEFAULT_GUARD_BITS,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PACKET_BITS-1:0] in_packet,
  output logic [PACKET_BITS-1:0] sort_packet,
  output logic                  sort_start,
  input  logic                  sort_done,
  input  logic [FRAME_BITS-1:0] sort_frame,
  input  logic                  abort,
  output logic                  bit_out,
  output logic                  bit_strobe,
  output logic                  tx_active,
  output logic                  frame_sent,
  output logic                  sort_timeout,
  output logic [15:0]           frames_sent
);

  localparam int unsigned CNT_MAX    = (FRAME_BITS > GUARD_BITS) ? FRAME_BITS : GUARD_BITS;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned FRAME_LAST = FRAME_BITS - 1;
  localparam int unsigned GUARD_LAST = (GUARD_BITS > 0) ? GUARD_BITS - 1 : 0;

  if (FRAME_BITS < 1 || BIT_PERIOD < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("tx_scheduler: FRAME_BITS, BIT_PERIOD and TIMEOUT_CYCLES must be at least 1");
  end

  tx_state_t              state, state_next;
  logic [PACKET_BITS-1:0] packet_q;
  logic [FRAME_BITS-1:0]  shift_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic [15:0]            frames_cnt;
  logic                   frame_sent_q;

  logic accept, load, frame_done, timed_out, wait_expired;
  logic timer_en, timer_clr, phase_strobe, last_phase;
  logic frame_last_bit, guard_last_bit;

  assign frame_last_bit = (bit_cnt == CNT_W'(FRAME_LAST));
  assign guard_last_bit = (bit_cnt == CNT_W'(GUARD_LAST));

  // The timer runs through SEND and GUARD so the guard period reuses the
  // same phase and bit counters; it is held clear everywhere else.
  assign timer_en  = (state == SEND) || (state == GUARD);
  assign timer_clr = load || !timer_en;

  bit_timer #(
    .PERIOD(BIT_PERIOD)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (timer_en),
    .clear     (timer_clr),
    .strobe    (phase_strobe),
    .last_phase(last_phase)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load       = 1'b0;
    frame_done = 1'b0;
    timed_out  = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            accept     = 1'b1;
            state_next = START;
          end
        end
        START: state_next = WAIT_SORT;
        WAIT_SORT: begin
          if (sort_done) begin
            load       = 1'b1;
            state_next = SEND;
          end else if (wait_expired) begin
            timed_out  = 1'b1;
            state_next = IDLE;
          end
        end
        SEND: begin
          if (last_phase && frame_last_bit) begin
            if (GUARD_BITS > 0) begin
              state_next = GUARD;
            end else begin
              frame_done = 1'b1;
              state_next = IDLE;
            end
          end
        end
        GUARD: begin
          if (last_phase && guard_last_bit) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      packet_q     <= '0;
      shift_q      <= '0;
      bit_cnt      <= '0;
      frames_cnt   <= '0;
      frame_sent_q <= 1'b0;
    end else begin
      state        <= state_next;
      frame_sent_q <= frame_done;
      if (accept) begin
        packet_q <= in_packet;
      end
      if (frame_done) begin
        frames_cnt <= frames_cnt + 16'd1;
      end
      if (load) begin
        shift_q <= sort_frame;
        bit_cnt <= '0;
      end else if (last_phase) begin
        if (state == SEND) begin
          shift_q <= shift_q >> 1;
        end
        bit_cnt <= ((state == SEND && frame_last_bit) || (state == GUARD && guard_last_bit))
                   ? '0 : bit_cnt + 1'b1;
      end
    end
  end

`ifdef TX_SCHEDULER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] wait_cnt;
  logic            timeout_q;

  always_ff @(posedge clk) begin
    if (reset || state != WAIT_SORT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timed_out;
    end
  end

  assign wait_expired = (state == WAIT_SORT) && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign sort_timeout = timeout_q;
`else
  assign wait_expired = 1'b0;
  assign sort_timeout = timed_out;
`endif

  assign in_ready    = (state == IDLE);
  assign sort_start  = (state == START);
  assign tx_active   = (state == SEND);
  assign bit_out     = tx_active && shift_q[0];
  assign bit_strobe  = tx_active && phase_strobe;
  assign frame_sent  = frame_sent_q;
  assign frames_sent = frames_cnt;
  assign sort_packet = packet_q;

endmodule
